// File: rtl/mem_arb_pkg.sv
// Shared definitions for the RAM port arbiter: owner state encoding,
// master ids and the lock counter width.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_t;

  localparam logic MID_M0 = 1'b0;
  localparam logic MID_M1 = 1'b1;

  localparam int unsigned LOCK_CNT_W = 8;

endpackage

// File: rtl/mem_arb_lock_timer.sv
// Lock timer for master 1. Counts consecutive locked master-1 grants,
// saturating at MAX_LOCK, and reports whether the lock still holds off
// master 0. The count clears when m1_lock drops or ownership leaves OWN1.
module mem_arb_lock_timer
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic clk,
  input  logic nreset,
  input  logic i_m1_gnt,
  input  logic i_m1_lock,
  input  logic i_stay_own1,
  output logic o_lock_ok
);

  localparam logic [LOCK_CNT_W-1:0] MAX_L = LOCK_CNT_W'(MAX_LOCK);

  logic [LOCK_CNT_W-1:0] r_cnt;
  logic [LOCK_CNT_W-1:0] w_cnt_next;

  // Count including the access granted this cycle; the lock is judged on
  // that value so master 1 gets exactly MAX_LOCK locked grants.
  always_comb begin
    w_cnt_next = r_cnt;
    if (!i_m1_lock) begin
      w_cnt_next = '0;
    end else if (i_m1_gnt) begin
      w_cnt_next = (r_cnt >= MAX_L) ? MAX_L : r_cnt + 1'b1;
    end
    o_lock_ok = i_m1_lock && (w_cnt_next < MAX_L);
  end

  // Hold the count only while master 1 keeps the port.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_cnt <= '0;
    end else if (i_stay_own1) begin
      r_cnt <= w_cnt_next;
    end else begin
      r_cnt <= '0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter for the single RAM port shared by the CPU control unit (master 0)
// and the boot loader / debug DMA (master 1). Owner FSM, address/data muxes
// and the shared read-return register.
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN for round-robin handover;
// otherwise master 0 has fixed priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 24,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  input  logic              m1_lock,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  arb_state_t        r_state;
  arb_state_t        w_next;
  logic              w_lock_ok;
  logic              r_m0_rvalid;
  logic              r_m1_rvalid;
  logic [DATA_W-1:0] r_rdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic              r_last;
`endif

  mem_arb_lock_timer #(
    .MAX_LOCK(MAX_LOCK)
  ) u_lock_timer (
    .clk        (clk),
    .nreset     (nreset),
    .i_m1_gnt   (m1_gnt),
    .i_m1_lock  (m1_lock),
    .i_stay_own1(w_next == ARB_OWN1),
    .o_lock_ok  (w_lock_ok)
  );

  // Grants and RAM-side muxing follow the current owner; nothing is driven in IDLE.
  always_comb begin
    m0_gnt      = 1'b0;
    m1_gnt      = 1'b0;
    ram_address = '0;
    ram_wdata   = '0;
    case (r_state)
      ARB_OWN0: begin
        m0_gnt      = m0_req;
        ram_address = m0_addr;
        ram_wdata   = m0_wdata;
      end
      ARB_OWN1: begin
        m1_gnt      = m1_req;
        ram_address = m1_addr;
        ram_wdata   = m1_wdata;
      end
      default: ;
    endcase
    ram_read  = (m0_gnt & ~m0_we) | (m1_gnt & ~m1_we);
    ram_write = (m0_gnt & m0_we) | (m1_gnt & m1_we);
  end

  // Next owner.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ARB_IDLE: begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (m0_req && m1_req) w_next = (r_last == MID_M1) ? ARB_OWN0 : ARB_OWN1;
        else if (m0_req)      w_next = ARB_OWN0;
`else
        if (m0_req)           w_next = ARB_OWN0;
`endif
        else if (m1_req)      w_next = ARB_OWN1;
        else                  w_next = ARB_IDLE;
      end
      ARB_OWN0: begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (m1_req)      w_next = ARB_OWN1;
        else if (m0_req) w_next = ARB_OWN0;
`else
        if (m0_req)      w_next = ARB_OWN0;
        else if (m1_req) w_next = ARB_OWN1;
`endif
        else             w_next = ARB_IDLE;
      end
      ARB_OWN1: begin
        if (m0_req && !w_lock_ok) w_next = ARB_OWN0;
        else if (m1_req)          w_next = ARB_OWN1;
        else if (m0_req)          w_next = ARB_OWN0;
        else                      w_next = ARB_IDLE;
      end
      default: w_next = ARB_IDLE;
    endcase
  end

  // Owner state and read return; reset discards any pending rvalid.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state     <= ARB_IDLE;
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_state     <= w_next;
      r_m0_rvalid <= m0_gnt & ~m0_we;
      r_m1_rvalid <= m1_gnt & ~m1_we;
      if (ram_read) r_rdata <= ram_rdata;
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Remember which master was served last to break ties in IDLE.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)     r_last <= MID_M1;
    else if (m0_gnt) r_last <= MID_M0;
    else if (m1_gnt) r_last <= MID_M1;
  end
`endif

  assign m0_rvalid = r_m0_rvalid;
  assign m1_rvalid = r_m1_rvalid;
  assign rdata     = r_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed per-cycle grant expectations plus a
// scoreboard of expected read returns.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        nreset;
  logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [23:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] rdata;
  logic        ram_read, ram_write;
  logic [23:0] ram_address;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  typedef struct {
    logic        who;
    logic [31:0] data;
  } sb_t;

  sb_t  q[$];
  logic pend = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W  (24),
    .DATA_W  (32),
    .MAX_LOCK(8)
  ) dut (
    .clk        (clk),
    .nreset     (nreset),
    .m0_req     (m0_req),
    .m0_we      (m0_we),
    .m0_addr    (m0_addr),
    .m0_wdata   (m0_wdata),
    .m0_gnt     (m0_gnt),
    .m0_rvalid  (m0_rvalid),
    .m1_req     (m1_req),
    .m1_we      (m1_we),
    .m1_addr    (m1_addr),
    .m1_wdata   (m1_wdata),
    .m1_gnt     (m1_gnt),
    .m1_rvalid  (m1_rvalid),
    .m1_lock    (m1_lock),
    .rdata      (rdata),
    .ram_read   (ram_read),
    .ram_write  (ram_write),
    .ram_address(ram_address),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: check grants and read returns at the falling edge,
  // queue expected data for reads granted now, then advance past the edge.
  task automatic step(input logic e0, input logic e1);
    sb_t it;
    @(negedge clk);
    check("m0_gnt", m0_gnt, e0);
    check("m1_gnt", m1_gnt, e1);
    if (pend) begin
      it = q.pop_front();
      check("m0_rvalid", m0_rvalid, it.who == 1'b0);
      check("m1_rvalid", m1_rvalid, it.who == 1'b1);
      check("rdata", rdata, it.data);
    end else begin
      check("m0_rvalid_idle", m0_rvalid, 1'b0);
      check("m1_rvalid_idle", m1_rvalid, 1'b0);
    end
    pend = 1'b0;
    if (e0 && !m0_we) begin
      q.push_back('{1'b0, ram_rdata});
      pend = 1'b1;
    end
    if (e1 && !m1_we) begin
      q.push_back('{1'b1, ram_rdata});
      pend = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    nreset = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    m1_lock = 1'b0; ram_rdata = '0;

    // Reset held with both requesting: everything quiet.
    #12;
    check("rst_m0_gnt", m0_gnt, 1'b0);
    check("rst_m1_gnt", m1_gnt, 1'b0);
    check("rst_ram_read", ram_read, 1'b0);
    check("rst_ram_write", ram_write, 1'b0);
    check("rst_ram_address", ram_address, 32'h0);
    check("rst_ram_wdata", ram_wdata, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_rvalid", {m0_rvalid, m1_rvalid}, 32'h0);
    @(negedge clk);
    nreset = 1'b1;
    #1;
    check("idle_after_release", m0_gnt, 1'b0);

    // Master-0 read of 0x000010.
    m1_req = 1'b0; m0_addr = 24'h000010; ram_rdata = 32'hDEADBEEF;
    @(posedge clk);
    #2;
    check("rd_ram_read", ram_read, 1'b1);
    check("rd_ram_write", ram_write, 1'b0);
    check("rd_ram_address", ram_address, 32'h000010);
    step(1'b1, 1'b0);
    m0_req = 1'b0;
    step(1'b0, 1'b0);

`ifndef MEM_ARB_ROUND_ROBIN_EN
    // Fixed priority: master 0 keeps the port while both request.
    m0_req = 1'b1; m1_req = 1'b1;
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      ram_rdata = 32'h0000_1000 + 32'(i);
      step(1'b1, 1'b0);
    end
    m0_req = 1'b0;
    m1_we = 1'b1; m1_addr = 24'h000020; m1_wdata = 32'h12345678;
    step(1'b0, 1'b0);
    #2;
    check("wr_ram_write", ram_write, 1'b1);
    check("wr_ram_read", ram_read, 1'b0);
    check("wr_ram_address", ram_address, 32'h000020);
    check("wr_ram_wdata", ram_wdata, 32'h12345678);
    step(1'b0, 1'b1);
    m1_req = 1'b0; m1_we = 1'b0;
    step(1'b0, 1'b0);
`endif

    // Locked burst of 12 with master 0 waiting: 8 grants then preemption.
    m1_req = 1'b1; m1_lock = 1'b1; m1_we = 1'b0;
    step(1'b0, 1'b0);
    m0_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ram_rdata = 32'h0000_2000 + 32'(i);
      step(1'b0, 1'b1);
    end
    ram_rdata = 32'h0000_2100;
    step(1'b1, 1'b0);
    m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0;
    step(1'b0, 1'b0);

    // Dropping m1_lock for one access restarts the lock count.
    m1_req = 1'b1; m1_lock = 1'b1; m1_we = 1'b1; m1_addr = 24'h000040;
    step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    m1_lock = 1'b0;
    step(1'b0, 1'b1);
    m1_lock = 1'b1; m0_req = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
    ram_rdata = 32'h0000_3000;
    step(1'b1, 1'b0);
    m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0; m1_we = 1'b0;
    step(1'b0, 1'b0);

    // Reset during a granted read: strobes drop, rvalid never appears.
    m0_req = 1'b1; m0_addr = 24'h000030; ram_rdata = 32'hCAFEF00D;
    step(1'b0, 1'b0);
    @(negedge clk);
    check("mid_gnt_before", m0_gnt, 1'b1);
    check("mid_read_before", ram_read, 1'b1);
    #2;
    nreset = 1'b0;
    #1;
    check("mid_read_dropped", ram_read, 1'b0);
    check("mid_gnt_dropped", m0_gnt, 1'b0);
    check("mid_addr_dropped", ram_address, 32'h0);
    @(posedge clk);
    #1;
    check("mid_rvalid_a", m0_rvalid, 1'b0);
    check("mid_rdata", rdata, 32'h0);
    @(negedge clk);
    check("mid_rvalid_b", m0_rvalid, 1'b0);
    m0_req = 1'b0;
    nreset = 1'b1;
    @(posedge clk);
    #1;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Round robin: first tie after reset goes to master 0, then alternates.
    m0_req = 1'b1; m1_req = 1'b1;
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      ram_rdata = 32'h0000_4000 + 32'(i);
      step(i % 2 == 0, i % 2 == 1);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    step(1'b0, 1'b0);
`else
    // Back in IDLE after reset: one cycle of arbitration latency.
    m0_req = 1'b1;
    step(1'b0, 1'b0);
    ram_rdata = 32'h0000_5000;
    step(1'b1, 1'b0);
    m0_req = 1'b0;
    step(1'b0, 1'b0);
`endif

    check("sb_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single RAM port between the CPU control unit (master 0: fetch, LDR, STR) and a secondary master (master 1: boot loader / debug DMA). It sits between both masters and the RAM and drives `ram_read`, `ram_write` and `ram_address` on their behalf. Master 1 may lock the port for multi-word bursts; a lock timer bounds how long it can hold the port. Losing masters see `gnt` low and must hold their request stable.

## Interface
- `ADDR_W`, 24, address width
- `DATA_W`, 32, data width
- `MAX_LOCK`, 8, maximum consecutive locked master-1 grants (1..255)

Ports:
- `clk` in 1: clock
- `nreset` in 1: reset, asynchronous, active-low
- `m0_req` in 1: master 0 access request
- `m0_we` in 1: master 0 write
- `m0_addr` in ADDR_W: master 0 address
- `m0_wdata` in DATA_W: master 0 write data
- `m0_gnt` out 1: access accepted this cycle
- `m0_rvalid` out 1: master 0 read data valid
- `m1_req`, `m1_we`, `m1_addr`, `m1_wdata`, `m1_gnt`, `m1_rvalid`: as for master 0, for master 1
- `m1_lock` in 1: master 1 requests to keep ownership after the current access
- `rdata` out DATA_W: registered RAM read data, shared by both masters
- `ram_read` out 1: RAM read strobe
- `ram_write` out 1: RAM write strobe
- `ram_address` out ADDR_W: RAM address
- `ram_wdata` out DATA_W: RAM write data
- `ram_rdata` in DATA_W: RAM read data, valid in the same cycle as `ram_read`

## Operation
- **States:** IDLE, OWN0, OWN1, held in a registered owner FSM.
- **In IDLE:**
  - No grants are issued and RAM strobes are 0.
  - On the next edge the state goes to OWN0 if `m0_req`, else to OWN1 if `m1_req`, else stays IDLE.
- **In OWNx:**
  - `mx_gnt = mx_req`.
  - `ram_read = mx_req & !mx_we`, `ram_write = mx_req & mx_we`.
  - `ram_address`, `ram_wdata` are muxed from master x.
  - The non-owner's gnt is 0.
- **Access completion:** an access completes on the edge where `gnt` is 1.
- **Read return:** a completed read registers `ram_rdata` into `rdata` and pulses that master's `rvalid` for one cycle on the next cycle.
- **Transitions from OWN0:**
  - Stay while `m0_req`.
  - Otherwise go to OWN1 if `m1_req`, else IDLE.
- **Transitions from OWN1:**
  - Go to OWN0 if `m0_req` and the lock is not effective.
  - Else stay if `m1_req`.
  - Else go to OWN0 if `m0_req`, else IDLE.
- **Lock effective:** `m1_lock & (lock_cnt < MAX_LOCK)`.
- **lock_cnt (8-bit):**
  - Increments on each granted master-1 access while `m1_lock` is high.
  - Clears on leaving OWN1 or when `m1_lock` is low.
  - Saturates at MAX_LOCK.
  - When saturated, master 0 preempts at the next edge if requesting.
- **Handover:** no idle cycle is inserted when ownership moves directly between masters.

## Timing
- **Reset values:** all outputs 0; state IDLE; `lock_cnt` 0; `rdata` 0.
- **Arbitration latency:**
  - 1 cycle from `req` rising in IDLE to `gnt`.
  - 0 cycles while the port is already owned by the requester.
- **Throughput:** 1 access per cycle to the owner.
- **Read data:** `rvalid` and `rdata` 1 cycle after the granted read edge.
- **Simultaneous requests in IDLE:** master 0 wins.
- **Owner drops `req` while the other is requesting:** switch at that edge, grant to the other in the next cycle.
- **Asynchronous reset mid-access:** strobes drop immediately. A pending `rvalid` is discarded and never asserted after reset.
- **`m1_lock` low on a master-1 access:** `lock_cnt` clears. A subsequent lock restarts the count.

## Configuration
- **`MEM_ARB_ROUND_ROBIN_EN` defined:**
  - From OWN0, after any granted access with `m1_req` high, go to OWN1.
  - From OWN1, after an unlocked granted access with `m0_req` high, go to OWN0.
  - In IDLE, simultaneous requests go to the master not served last. A last-served register resets to 1, so master 0 wins the first tie.
- **Undefined:** fixed priority as described under Operation (master 0 holds the port while requesting).

## Structure
- **Package `mem_arb_pkg`:** owner state encoding (`ARB_IDLE=2'd0`, `ARB_OWN0=2'd1`, `ARB_OWN1=2'd2`) and master id constants.
- **Sub-module `mem_arb_lock_timer`:** `lock_cnt` with clear, increment and saturate logic. It outputs `lock_ok`.
- **Top level:** FSM, muxes and read-return register.

## Test plan
- **Reset:** hold `nreset` low with both requests high -> all outputs 0. First release edge -> OWN0; `m0_gnt=1` in the following cycle.
- **Master-0 read:** `m0_req`, addr `0x000010`, `ram_rdata=0xDEADBEEF` -> `ram_read=1`, `ram_address=0x000010`; next cycle `m0_rvalid=1`, `rdata=0xDEADBEEF`, `m1_rvalid=0`.
- **Fixed priority, both requesting 4 cycles:** only `m0_gnt`. Drop `m0_req` -> `m1_gnt` the next cycle; a master-1 write to `0x000020` of `0x12345678` drives `ram_write=1`, `ram_wdata=0x12345678`.
- **Lock timeout, `MAX_LOCK=8`:** master 1 locked burst of 12 with `m0_req` high throughout -> exactly 8 `m1_gnt` cycles, then `m0_gnt`.
- **Round robin (macro on), both requesting:** grants alternate m0, m1, m0, m1 with no idle cycle.
- **Reset mid-read:** assert `nreset` low on the cycle after a granted read -> `m0_rvalid` never pulses; state IDLE after release.
